// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per clock.
// Result is {remainder, quotient}. Sign fix is applied on the final step.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               start,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] dvd;   // dividend, shifts out as quotient bits shift in
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic             neg_q;
    logic             neg_r;
  } op_t;

  state_t             state, nxt;
  op_t                op;
  logic [CW-1:0]      cnt;
  logic               ready_d;
  logic [2*WIDTH-1:0] result_d;

  logic               accept;
  logic [WIDTH:0]     trial, diff;
  logic               qbit;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt, quo_fix, rem_fix;
  logic [WIDTH-1:0]   abs1, abs2;

  assign accept = (state == FREE) && start && !annul;
  assign abs1   = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
  assign abs2   = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

  // Restoring step: bring the next dividend bit into the partial remainder.
  assign trial   = {op.rem, op.dvd[WIDTH-1]};
  assign diff    = trial - {1'b0, op.dvs};
  assign qbit    = (trial >= {1'b0, op.dvs});
  assign rem_nxt = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nxt = {op.dvd[WIDTH-2:0], qbit};
  assign quo_fix = op.neg_q ? -quo_nxt : quo_nxt;
  assign rem_fix = op.neg_r ? -rem_nxt : rem_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FREE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      FREE:    if (start && !annul) nxt = (opdata2 == '0) ? BY_ZERO : ON;
      BY_ZERO: nxt = annul ? FREE : END;
      ON:      if (annul) nxt = FREE;
               else if (cnt == LAST) nxt = END;
      END:     if (!start) nxt = FREE;
      default: nxt = FREE;
    endcase
  end

  always_comb begin
    ready_d  = ready;
    result_d = result;
    case (state)
      BY_ZERO: begin
        ready_d  = !annul;
        result_d = '0;
      end
      ON: begin
        if (annul) begin
          ready_d  = 1'b0;
          result_d = '0;
        end else if (cnt == LAST) begin
          ready_d  = 1'b1;
          result_d = {rem_fix, quo_fix};
        end
      end
      END: begin
        if (!start) begin
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op     <= '0;
      cnt    <= '0;
      ready  <= 1'b0;
      result <= '0;
    end else begin
      ready  <= ready_d;
      result <= result_d;
      if (accept) begin
        op.dvd   <= abs1;
        op.dvs   <= abs2;
        op.rem   <= '0;
        op.neg_q <= signed_div && (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
        op.neg_r <= signed_div && opdata1[WIDTH-1];
        cnt      <= '0;
      end else if (state == ON) begin
        op.dvd <= quo_nxt;
        op.rem <= rem_nxt;
        cnt    <= cnt + 1'b1;
      end
    end
  end
endmodule
